// File: rtl/phase_sampler.sv
// ---------------------------------------------------------------------------
// phase_sampler
//   Per-spin readout stage behind an Ising coupling cell. Synchronizes the
//   cell oscillator, the reference oscillator and the array run enable into
//   clk, waits a programmable settle time after a run starts, counts phase
//   disagreements over a programmable sample window and resolves the spin
//   by majority. Config and status sit on the cells' 32-bit register port.
//
//   Optional feature macro: PHASE_SAMPLER_GLITCH_FILTER_EN
//     defined   : 3-tap majority filter on osc_s/ref_s ahead of the XOR
//     undefined : XOR taken directly from the synchronizer outputs
//
// Parameters
//   WIDTH     settle/window/mismatch counter width (4..16)
//   NUM_SYNC  synchronizer depth on each async input (>= 2)
//
// Ports
//   clk            single clock
//   axi_rst        synchronous active-high reset
//   ising_rstn     array run enable, async (low = spins held)
//   osc_in         cell oscillator output, async
//   ref_in         reference oscillator, async
//   wready         register write strobe
//   wr_addr_match  write address selects this block
//   wdata          [WIDTH-1:0] window_len, [16+WIDTH-1:16] settle_len
//   rdata          [0] spin, [1] done, [2] busy, [16+WIDTH-1:16] mismatch
// ---------------------------------------------------------------------------
module phase_sampler #(
   parameter int WIDTH    = 16,
   parameter int NUM_SYNC = 2
) (
   input  logic        clk,
   input  logic        axi_rst,
   input  logic        ising_rstn,
   input  logic        osc_in,
   input  logic        ref_in,
   input  logic        wready,
   input  logic        wr_addr_match,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam logic [WIDTH-1:0] WIN_RST = WIDTH'(256);
   localparam logic [WIDTH-1:0] SET_RST = WIDTH'(64);

   // ------------------------------------------------------------------
   // Input synchronizers (bit 0 is the first flop)
   // ------------------------------------------------------------------
   logic [NUM_SYNC-1:0] osc_sync, ref_sync, run_sync;
   logic                osc_s, ref_s, run_s, run_prev, run_rise;

   always_ff @(posedge clk) begin
      if (axi_rst) begin
         osc_sync <= '0;
         ref_sync <= '0;
         run_sync <= '0;
         run_prev <= 1'b0;
      end else begin
         osc_sync <= {osc_sync[NUM_SYNC-2:0], osc_in};
         ref_sync <= {ref_sync[NUM_SYNC-2:0], ref_in};
         run_sync <= {run_sync[NUM_SYNC-2:0], ising_rstn};
         run_prev <= run_s;
      end
   end

   assign osc_s    = osc_sync[NUM_SYNC-1];
   assign ref_s    = ref_sync[NUM_SYNC-1];
   assign run_s    = run_sync[NUM_SYNC-1];
   assign run_rise = run_s & ~run_prev;

   // ------------------------------------------------------------------
   // Phase comparison, optionally de-glitched
   // ------------------------------------------------------------------
   logic osc_p, ref_p, phase_diff;

`ifdef PHASE_SAMPLER_GLITCH_FILTER_EN
   logic [2:0] osc_flt, ref_flt;

   always_ff @(posedge clk) begin
      if (axi_rst) begin
         osc_flt <= '0;
         ref_flt <= '0;
      end else begin
         osc_flt <= {osc_flt[1:0], osc_s};
         ref_flt <= {ref_flt[1:0], ref_s};
      end
   end

   // 2-of-3 vote: an isolated one-cycle pulse never wins
   assign osc_p = (osc_flt[0] & osc_flt[1]) | (osc_flt[0] & osc_flt[2]) |
                  (osc_flt[1] & osc_flt[2]);
   assign ref_p = (ref_flt[0] & ref_flt[1]) | (ref_flt[0] & ref_flt[2]) |
                  (ref_flt[1] & ref_flt[2]);
`else
   assign osc_p = osc_s;
   assign ref_p = ref_s;
`endif

   assign phase_diff = osc_p ^ ref_p;

   // ------------------------------------------------------------------
   // Control / datapath
   // ------------------------------------------------------------------
   state_t           state;
   logic [WIDTH-1:0] window_len, settle_len;
   logic [WIDTH-1:0] cnt, mismatch;
   logic             spin, done;

   logic [WIDTH-1:0] win_eff;
   logic [WIDTH:0]   cnt_inc;
   logic [WIDTH-1:0] mis_nxt;
   logic             wr_en, busy;

   // A zero window would never terminate; run it as a single sample
   assign win_eff = (window_len == '0) ? WIDTH'(1) : window_len;
   assign cnt_inc = {1'b0, cnt} + (WIDTH+1)'(1);
   // Cannot wrap: mismatch never exceeds the window length
   assign mis_nxt = mismatch + WIDTH'(phase_diff);
   assign wr_en   = wready & wr_addr_match;
   assign busy    = (state == SETTLE) || (state == SAMPLE);

   logic [31:0] status;
   always_comb begin
      status             = '0;
      status[0]          = spin;
      status[1]          = done;
      status[2]          = busy;
      status[16 +: WIDTH] = mismatch;
   end

   always_ff @(posedge clk) begin
      if (axi_rst) begin
         state      <= IDLE;
         window_len <= WIN_RST;
         settle_len <= SET_RST;
         cnt        <= '0;
         mismatch   <= '0;
         spin       <= 1'b0;
         done       <= 1'b0;
         rdata      <= '0;
      end else begin
         rdata <= status;

         // Config is frozen while a measurement is in flight
         if (wr_en && (state == IDLE || state == DONE)) begin
            window_len <= wdata[WIDTH-1:0];
            settle_len <= wdata[16 +: WIDTH];
         end

         case (state)
            IDLE: begin
               if (run_rise) begin
                  state    <= SETTLE;
                  cnt      <= '0;
                  mismatch <= '0;
                  done     <= 1'b0;
               end
            end

            SETTLE: begin
               if (!run_s) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  mismatch <= '0;
                  spin     <= 1'b0;
                  done     <= 1'b0;
               end else if (cnt_inc >= {1'b0, settle_len}) begin
                  // settle_len of 0 still spends this one cycle here
                  state <= SAMPLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc[WIDTH-1:0];
               end
            end

            SAMPLE: begin
               if (!run_s) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  mismatch <= '0;
                  spin     <= 1'b0;
                  done     <= 1'b0;
               end else begin
                  mismatch <= mis_nxt;
                  if (cnt_inc == {1'b0, win_eff}) begin
                     state <= DONE;
                     done  <= 1'b1;
                     // Strict majority; a tie resolves to 0
                     spin  <= ({mis_nxt, 1'b0} > {1'b0, win_eff});
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc[WIDTH-1:0];
                  end
               end
            end

            DONE: begin
               // Result and done stay visible after the run drops
               if (!run_s) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/phase_sampler.md
# phase_sampler

Per-spin readout stage downstream of an Ising coupling cell. It takes one cell's free-running oscillator output and a global reference oscillator, both asynchronous to `clk`. Over a programmable window, it counts the cycles on which the two disagree in phase and resolves the final spin by majority. The result is exposed on the same 32-bit AXI register interface used by the cells, so software reads the settled spin after a run.

## Interface

Parameters:
- `WIDTH`, 16: settle/window/mismatch counter width; legal range 4..16.
- `NUM_SYNC`, 2: synchronizer flop stages on each async input; minimum 2.

Ports:
- `clk`  in  1  single clock for all logic.
- `axi_rst`  in  1  synchronous, active-high reset.
- `ising_rstn`  in  1  array run enable (low = spins held at start value). Asynchronous to `clk`; synchronized internally.
- `osc_in`  in  1  cell oscillator output (cell `tout`). Asynchronous.
- `ref_in`  in  1  reference oscillator. Asynchronous.
- `wready`  in  1  AXI write strobe.
- `wr_addr_match`  in  1  write address selects this block.
- `wdata`  in  32  write data: `[WIDTH-1:0]` = window_len, `[16+WIDTH-1:16]` = settle_len.
- `rdata`  out  32  status: `[0]` spin, `[1]` done, `[2]` busy, `[15:3]` zero, `[16+WIDTH-1:16]` mismatch count, rest zero.

## Operation

- **Synchronization.** `osc_in`, `ref_in` and `ising_rstn` each pass through `NUM_SYNC` flops (reset 0), giving `osc_s`, `ref_s` and `run_s`. `run_rise` = `run_s` high while its previous value was low.
- **Config write.** On `wready & wr_addr_match`, window_len and settle_len load from `wdata`.
  - Writes are accepted only in IDLE or DONE; writes in SETTLE or SAMPLE are dropped.
  - A window_len of 0 is treated as 1.
  - Reset values: window_len = 256, settle_len = 64 (both truncated to `WIDTH` bits).
- **FSM.**
  - **IDLE → SETTLE** on `run_rise`. Clears the cycle counter, the mismatch count and `done`.
  - **SETTLE:** counts settle_len cycles, then goes to SAMPLE. With settle_len = 0, SETTLE lasts exactly one cycle.
  - **SAMPLE:** each cycle, mismatch += (`osc_s` ^ `ref_s`) and the sample count increments. After window_len samples, go to DONE.
  - **DONE:** holds spin and mismatch; `done` = 1. Return to IDLE when `run_s` = 0; result and `done` stay held.
  - A new `run_rise` seen in IDLE restarts the sequence.
  - **Abort:** `run_s` = 0 while in SETTLE or SAMPLE → IDLE next cycle. `done` = 0, mismatch cleared, spin = 0.
- **Spin decision.** Latched on entry to DONE. spin = (2·mismatch > window_len), computed at `WIDTH+1` bits. A tie gives 0.
- **Counter bounds.** The mismatch count cannot exceed window_len, so no saturation logic is needed.
- **busy** = 1 in SETTLE or SAMPLE.

## Timing

- After `axi_rst`:
  - state IDLE;
  - `rdata` = 0;
  - all synchronizer flops 0.
- `axi_rst` asserted in any state forces IDLE the next cycle and clears all registers. It takes priority over a simultaneous write.
- Input-to-`run_s` latency is `NUM_SYNC` cycles; `run_rise` is detected one cycle after that.
- The edge at cycle t puts the FSM in SETTLE at t+1. SAMPLE begins at t+1+max(settle_len,1). `done` rises on the cycle after the last sample.
- `rdata` is registered: it reflects state one cycle after the update.
- `run_s` low and a write in the same DONE cycle: both take effect.

## Configuration

- **`PHASE_SAMPLER_GLITCH_FILTER_EN`**
  - **Defined:** `osc_s` and `ref_s` each pass through a 3-tap majority filter (3-flop shift register, reset 0) before the XOR. This adds 2 cycles of input latency and suppresses single-cycle pulses; FSM timing is unchanged.
  - **Undefined:** the XOR uses the synchronizer outputs directly.

## Test plan

1. **Reset.** Assert `axi_rst` 3 cycles → `rdata` = 0. Start a run with no write → done after 64 settle + 256 sample cycles.
2. **In phase.** Write settle 10, window 100. Drive `osc_in` = `ref_in` at period 8. Raise `ising_rstn` → `done` = 1, mismatch = 0, spin = 0, `busy` low after 110 FSM cycles.
3. **Anti-phase.** Same config, `osc_in` = ~`ref_in` → mismatch = 100, spin = 1.
4. **Tie.** Window 100, `osc_in` quarter-period offset from `ref_in` (period 8) → mismatch = 50, spin = 0. Repeat with period-8 offset 3 → mismatch ≈ 75, spin = 1.
5. **Abort / dropped write.**
   - Drop `ising_rstn` at sample 40 → IDLE, `done` = 0, mismatch = 0.
   - Write window 20 during SAMPLE → the next run still uses 100.
6. **Reset mid-run and glitch filter.**
   - `axi_rst` during SAMPLE → `rdata` = 0 next cycle.
   - With `PHASE_SAMPLER_GLITCH_FILTER_EN`, a 1-cycle pulse on `osc_in` with `ref_in` = 0 → mismatch = 0.
